pit_ctl: RTL and testbench

PIT_CTL -- requirements
Module: pit_ctl

---
 rtl/pit_ctl.sv | 244 ++++++++++++++++++++++++
 tb/tb_pit_ctl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pit_ctl.sv
// Bus sequencer for an 8254-style interval timer: power-up programming of three
// channels, then round-robin arbitration between host accesses and latched-count snapshots.
module pit_ctl #(
  parameter logic [2:0]  MODE0   = 3'd3,
  parameter logic [2:0]  MODE1   = 3'd2,
  parameter logic [2:0]  MODE2   = 3'd0,
  parameter logic        BCD0    = 1'b0,
  parameter logic        BCD1    = 1'b0,
  parameter logic        BCD2    = 1'b0,
  parameter logic [15:0] RELOAD0 = 16'd2,
  parameter logic [15:0] RELOAD1 = 16'd2,
  parameter logic [15:0] RELOAD2 = 16'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [1:0]  host_a,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  input  logic        snap_req,
  input  logic [1:0]  snap_ch,
  output logic        snap_ack,
  output logic [15:0] snap_val,
  output logic        init_done,
  output logic        pit_cs,
  output logic        pit_rd,
  output logic        pit_wr,
  output logic [1:0]  pit_a,
  output logic [7:0]  pit_wdata,
  input  logic [7:0]  pit_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_GAP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_INIT, OWN_HOST, OWN_SNAP} owner_t;

  // Per-channel control word and reload value; entry 3 is padding for 2-bit indexing.
  logic [7:0]  ctrl_word  [4];
  logic [15:0] reload_val [4];

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign ctrl_word[gi] = {2'(gi), 2'b11,
                            (gi == 0) ? MODE0 : (gi == 1) ? MODE1 : MODE2,
                            (gi == 0) ? BCD0  : (gi == 1) ? BCD1  : BCD2};
    assign reload_val[gi] = (gi == 0) ? RELOAD0 : (gi == 1) ? RELOAD1 : RELOAD2;
  end
  assign ctrl_word[3]  = 8'h00;
  assign reload_val[3] = 16'h0000;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [1:0]  init_ch_q, init_ch_d;
  logic [1:0]  init_sub_q, init_sub_d;
  logic        init_done_q, init_done_d;
  logic        rr_snap_q, rr_snap_d;
  logic [1:0]  snap_step_q, snap_step_d;
  logic [1:0]  snap_ch_q, snap_ch_d;
  logic [7:0]  snap_lsb_q, snap_lsb_d;
  logic        acc_we_q, acc_we_d;
  logic [1:0]  pit_a_q, pit_a_d;
  logic [7:0]  pit_wdata_q, pit_wdata_d;
  logic        pit_cs_q, pit_cs_d;
  logic        pit_rd_q, pit_rd_d;
  logic        pit_wr_q, pit_wr_d;
  logic        host_ack_q, host_ack_d;
  logic [7:0]  host_rdata_q, host_rdata_d;
  logic        snap_ack_q, snap_ack_d;
  logic [15:0] snap_val_q, snap_val_d;
  logic        load_init;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    init_ch_d    = init_ch_q;
    init_sub_d   = init_sub_q;
    init_done_d  = init_done_q;
    rr_snap_d    = rr_snap_q;
    snap_step_d  = snap_step_q;
    snap_ch_d    = snap_ch_q;
    snap_lsb_d   = snap_lsb_q;
    acc_we_d     = acc_we_q;
    pit_a_d      = pit_a_q;
    pit_wdata_d  = pit_wdata_q;
    host_rdata_d = host_rdata_q;
    snap_val_d   = snap_val_q;
    host_ack_d   = 1'b0;
    snap_ack_d   = 1'b0;
    load_init    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!init_done_q) begin
          owner_d    = OWN_INIT;
          init_ch_d  = 2'd0;
          init_sub_d = 2'd0;
          load_init  = 1'b1;
          state_d    = S_SETUP;
        end else if (host_req && (!snap_req || !rr_snap_q)) begin
          owner_d     = OWN_HOST;
          acc_we_d    = host_we;
          pit_a_d     = host_a;
          pit_wdata_d = host_wdata;
          rr_snap_d   = 1'b1;
          state_d     = S_SETUP;
        end else if (snap_req) begin
          rr_snap_d = 1'b0;
          if (snap_ch == 2'd3) begin
            // No such counter: acknowledge at once with a zero value and leave the bus idle.
            owner_d    = OWN_NONE;
            snap_ack_d = 1'b1;
            snap_val_d = 16'h0000;
            state_d    = S_GAP;
          end else begin
            owner_d     = OWN_SNAP;
            snap_step_d = 2'd0;
            snap_ch_d   = snap_ch;
            acc_we_d    = 1'b1;
            pit_a_d     = 2'd3;
            pit_wdata_d = {snap_ch, 6'b000000};
            state_d     = S_SETUP;
          end
        end
      end
      S_SETUP: state_d = S_STROBE;
      S_STROBE: begin
        state_d = S_GAP;
        if (owner_q == OWN_HOST) begin
          host_ack_d = 1'b1;
          if (!acc_we_q) host_rdata_d = pit_rdata;
        end
        if (owner_q == OWN_SNAP) begin
          if (snap_step_q == 2'd1) snap_lsb_d = pit_rdata;
          if (snap_step_q == 2'd2) begin
            snap_val_d = {pit_rdata, snap_lsb_q};
            snap_ack_d = 1'b1;
          end
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
        case (owner_q)
          OWN_INIT: begin
            if (init_sub_q == 2'd2) begin
              if (init_ch_q == 2'd2) begin
                init_done_d = 1'b1;
              end else begin
                init_ch_d  = init_ch_q + 2'd1;
                init_sub_d = 2'd0;
                load_init  = 1'b1;
                state_d    = S_SETUP;
              end
            end else begin
              init_sub_d = init_sub_q + 2'd1;
              load_init  = 1'b1;
              state_d    = S_SETUP;
            end
          end
          OWN_SNAP: begin
            if (snap_step_q != 2'd2) begin
              snap_step_d = snap_step_q + 2'd1;
              acc_we_d    = 1'b0;
              pit_a_d     = snap_ch_q;
              pit_wdata_d = 8'h00;
              state_d     = S_SETUP;
            end
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    if (load_init) begin
      acc_we_d = 1'b1;
      case (init_sub_d)
        2'd0:    begin pit_a_d = 2'd3;      pit_wdata_d = ctrl_word[init_ch_d];        end
        2'd1:    begin pit_a_d = init_ch_d; pit_wdata_d = reload_val[init_ch_d][7:0];  end
        default: begin pit_a_d = init_ch_d; pit_wdata_d = reload_val[init_ch_d][15:8]; end
      endcase
    end

    // Strobes are registered from the next state so they line up exactly with it.
    pit_cs_d = (state_d == S_SETUP) || (state_d == S_STROBE);
    pit_rd_d = (state_d == S_STROBE) && !acc_we_d;
    pit_wr_d = (state_d == S_STROBE) && acc_we_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_NONE;
      init_ch_q    <= 2'd0;
      init_sub_q   <= 2'd0;
      init_done_q  <= 1'b0;
      rr_snap_q    <= 1'b0;
      snap_step_q  <= 2'd0;
      snap_ch_q    <= 2'd0;
      snap_lsb_q   <= 8'h00;
      acc_we_q     <= 1'b0;
      pit_a_q      <= 2'd0;
      pit_wdata_q  <= 8'h00;
      pit_cs_q     <= 1'b0;
      pit_rd_q     <= 1'b0;
      pit_wr_q     <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= 8'h00;
      snap_ack_q   <= 1'b0;
      snap_val_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      init_ch_q    <= init_ch_d;
      init_sub_q   <= init_sub_d;
      init_done_q  <= init_done_d;
      rr_snap_q    <= rr_snap_d;
      snap_step_q  <= snap_step_d;
      snap_ch_q    <= snap_ch_d;
      snap_lsb_q   <= snap_lsb_d;
      acc_we_q     <= acc_we_d;
      pit_a_q      <= pit_a_d;
      pit_wdata_q  <= pit_wdata_d;
      pit_cs_q     <= pit_cs_d;
      pit_rd_q     <= pit_rd_d;
      pit_wr_q     <= pit_wr_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
      snap_ack_q   <= snap_ack_d;
      snap_val_q   <= snap_val_d;
    end
  end

  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign snap_ack   = snap_ack_q;
  assign snap_val   = snap_val_q;
  assign init_done  = init_done_q;
  assign pit_cs     = pit_cs_q;
  assign pit_rd     = pit_rd_q;
  assign pit_wr     = pit_wr_q;
  assign pit_a      = pit_a_q;
  assign pit_wdata  = pit_wdata_q;

endmodule

// File: tb/tb_pit_ctl.sv
// Self-checking bench for pit_ctl: behavioural 8254 latch model, bus monitor,
// directed power-up/abort/arbitration steps and randomized host/snapshot traffic.
module tb_pit_ctl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [1:0]  host_a = 2'd0;
  logic [7:0]  host_wdata = 8'h00;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        snap_req = 1'b0;
  logic [1:0]  snap_ch = 2'd0;
  logic        snap_ack;
  logic [15:0] snap_val;
  logic        init_done;
  logic        pit_cs, pit_rd, pit_wr;
  logic [1:0]  pit_a;
  logic [7:0]  pit_wdata;
  logic [7:0]  pit_rdata;

  always #5 clk = ~clk;

  pit_ctl dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_we(host_we), .host_a(host_a), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .snap_req(snap_req), .snap_ch(snap_ch), .snap_ack(snap_ack), .snap_val(snap_val),
    .init_done(init_done),
    .pit_cs(pit_cs), .pit_rd(pit_rd), .pit_wr(pit_wr), .pit_a(pit_a),
    .pit_wdata(pit_wdata), .pit_rdata(pit_rdata)
  );

  // Timer model: running counts, plain read registers, and a latch that returns LSB then MSB.
  logic [15:0] cnt     [4];
  logic [7:0]  rd_reg  [4];
  logic        lat_pend[4];
  logic        lat_msb [4];
  logic [15:0] lat_val [4];

  always_comb begin
    pit_rdata = 8'hEE;
    if (pit_rd) begin
      if (pit_a != 2'd3 && lat_pend[pit_a])
        pit_rdata = lat_msb[pit_a] ? lat_val[pit_a][15:8] : lat_val[pit_a][7:0];
      else
        pit_rdata = rd_reg[pit_a];
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) lat_pend[i] <= 1'b0;
    end else begin
      if (pit_wr && pit_a == 2'd3 && pit_wdata[5:4] == 2'b00 && pit_wdata[7:6] != 2'd3) begin
        lat_pend[pit_wdata[7:6]] <= 1'b1;
        lat_msb[pit_wdata[7:6]]  <= 1'b0;
        lat_val[pit_wdata[7:6]]  <= cnt[pit_wdata[7:6]];
      end
      if (pit_rd && pit_a != 2'd3 && lat_pend[pit_a]) begin
        if (lat_msb[pit_a]) lat_pend[pit_a] <= 1'b0;
        else                lat_msb[pit_a]  <= 1'b1;
      end
    end
  end

  int cyc;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Bus monitor: logs strobes with their cycle and counts protocol violations.
  logic [9:0] wr_q[$];
  int         wr_cyc[$];
  logic [1:0] rd_a_q[$];
  int         rd_cyc[$];
  int host_ack_cnt = 0, snap_ack_cnt = 0, cs_cnt = 0, viol = 0;
  logic       prev_cs = 1'b0, prev_str = 1'b0;
  logic [1:0] prev_a = 2'd0;
  logic [7:0] prev_wd = 8'h00;

  always @(negedge clk) begin
    if (pit_cs) cs_cnt++;
    if ((pit_rd || pit_wr) && !pit_cs) viol++;
    if (pit_rd && pit_wr) viol++;
    if ((pit_rd || pit_wr) && !(prev_cs && !prev_str && prev_a == pit_a && prev_wd == pit_wdata)) viol++;
    if (prev_str && (pit_cs || pit_rd || pit_wr)) viol++;
    if (host_ack && snap_ack) viol++;
    if (host_ack) host_ack_cnt++;
    if (snap_ack) snap_ack_cnt++;
    if (pit_wr) begin wr_q.push_back({pit_a, pit_wdata}); wr_cyc.push_back(cyc); end
    if (pit_rd) begin rd_a_q.push_back(pit_a); rd_cyc.push_back(cyc); end
    prev_cs  = pit_cs;
    prev_str = pit_rd || pit_wr;
    prev_a   = pit_a;
    prev_wd  = pit_wdata;
  end

  int checks = 0, passed = 0, fails = 0;
  logic [7:0] exp_rdata = 8'h00;
  logic [9:0] exp_init [9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_q.delete(); wr_cyc.delete(); rd_a_q.delete(); rd_cyc.delete();
  endtask

  // Called at the negedge of cycle 0; returns at the negedge where init_done is first seen.
  task automatic check_init(input string pfx);
    int done_c = -1;
    for (int k = 0; k < 60; k++) begin
      if (init_done) begin done_c = cyc; break; end
      @(negedge clk);
    end
    chk({pfx, "_done_cycle"}, done_c, 28);
    chk({pfx, "_no_ack"}, host_ack_cnt + snap_ack_cnt, 0);
    chk({pfx, "_wr_count"}, wr_q.size(), 9);
    chk({pfx, "_rd_count"}, rd_cyc.size(), 0);
    for (int i = 0; i < 9; i++) begin
      if (i < wr_q.size()) begin
        chk($sformatf("%s_wr%0d_data", pfx, i), wr_q[i], exp_init[i]);
        chk($sformatf("%s_wr%0d_cycle", pfx, i), wr_cyc[i], 2 + 3 * i);
      end
    end
  endtask

  task automatic do_host(input logic we, input logic [1:0] a, input logic [7:0] d);
    int t, c = -1, nrd, nwr;
    @(negedge clk);
    nrd = rd_cyc.size(); nwr = wr_cyc.size();
    if (!we) rd_reg[a] = d;
    host_req = 1'b1; host_we = we; host_a = a; host_wdata = d; t = cyc;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (host_ack) begin c = cyc; break; end
    end
    host_req = 1'b0;
    if (!we) exp_rdata = d;
    $display("host %s a=%0d d=%02h t=%0d ack=%0d rdata=%02h", we ? "wr" : "rd", a, d, t, c, host_rdata);
    chk("host_ack_cycle", c, t + 3);
    chk("host_rdata", host_rdata, exp_rdata);
    chk("host_wr_count", wr_cyc.size() - nwr, we ? 1 : 0);
    chk("host_rd_count", rd_cyc.size() - nrd, we ? 0 : 1);
    if (we && wr_cyc.size() > nwr) begin
      chk("host_wr_bus", wr_q[nwr], {a, d});
      chk("host_wr_cycle", wr_cyc[nwr], t + 2);
    end
    if (!we && rd_cyc.size() > nrd) begin
      chk("host_rd_addr", rd_a_q[nrd], a);
      chk("host_rd_cycle", rd_cyc[nrd], t + 2);
    end
  endtask

  task automatic do_snap(input logic [1:0] ch, input logic [15:0] v);
    int t, c = -1, nrd, nwr, cs0;
    logic [15:0] exp_v;
    @(negedge clk);
    nrd = rd_cyc.size(); nwr = wr_cyc.size(); cs0 = cs_cnt;
    cnt[ch] = v;
    exp_v = (ch == 2'd3) ? 16'h0000 : v;
    snap_req = 1'b1; snap_ch = ch; t = cyc;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (snap_ack) begin c = cyc; break; end
    end
    snap_req = 1'b0;
    $display("snap ch=%0d t=%0d ack=%0d val=%04h", ch, t, c, snap_val);
    chk("snap_val", snap_val, exp_v);
    chk("snap_keeps_host_rdata", host_rdata, exp_rdata);
    if (ch == 2'd3) begin
      chk("snap3_ack_cycle", c, t + 1);
      @(negedge clk);
      chk("snap3_no_cs", cs_cnt - cs0, 0);
      chk("snap3_no_strobes", (wr_cyc.size() - nwr) + (rd_cyc.size() - nrd), 0);
    end else begin
      chk("snap_ack_cycle", c, t + 9);
      chk("snap_wr_count", wr_cyc.size() - nwr, 1);
      chk("snap_rd_count", rd_cyc.size() - nrd, 2);
      if (wr_cyc.size() > nwr) begin
        chk("snap_latch_cmd", wr_q[nwr], {2'd3, ch, 6'b000000});
        chk("snap_latch_cycle", wr_cyc[nwr], t + 2);
      end
      if (rd_cyc.size() > nrd + 1) begin
        chk("snap_rd_addr", {rd_a_q[nrd], rd_a_q[nrd + 1]}, {ch, ch});
        chk("snap_rd_lsb_cycle", rd_cyc[nrd], t + 5);
        chk("snap_rd_msb_cycle", rd_cyc[nrd + 1], t + 8);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, c, sa0, r;
    logic [1:0] ra;
    logic [7:0] rd0;
    logic [15:0] cnt0;

    exp_init[0] = {2'd3, 8'h36}; exp_init[1] = {2'd0, 8'h02}; exp_init[2] = {2'd0, 8'h00};
    exp_init[3] = {2'd3, 8'h74}; exp_init[4] = {2'd1, 8'h02}; exp_init[5] = {2'd1, 8'h00};
    exp_init[6] = {2'd3, 8'hB0}; exp_init[7] = {2'd2, 8'h02}; exp_init[8] = {2'd2, 8'h00};
    for (int i = 0; i < 4; i++) begin cnt[i] = 16'($urandom); rd_reg[i] = 8'($urandom); end
    rd_reg[1] = 8'h5A;

    repeat (3) @(negedge clk);
    chk("reset_bus", {pit_cs, pit_rd, pit_wr, pit_a, pit_wdata}, 0);
    chk("reset_status", {host_ack, snap_ack, init_done, host_rdata, snap_val}, 0);
    clear_log();

    // Host read held through init must be ignored until init_done, then granted at cycle 28.
    host_req = 1'b1; host_we = 1'b0; host_a = 2'd1;
    reset = 1'b0;
    check_init("init");
    t = cyc; c = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (host_ack) begin c = cyc; break; end
    end
    host_req = 1'b0;
    exp_rdata = 8'h5A;
    $display("host rd a=1 after init t=%0d ack=%0d rdata=%02h", t, c, host_rdata);
    chk("first_host_ack_cycle", c, 31);
    chk("first_host_rdata", host_rdata, 8'h5A);
    chk("first_host_rd_count", rd_cyc.size(), 1);
    if (rd_cyc.size() > 0) begin
      chk("first_host_rd_cycle", rd_cyc[0], 30);
      chk("first_host_rd_addr", rd_a_q[0], 1);
    end

    do_snap(2'd2, 16'h1234);
    do_snap(2'd3, 16'hBEEF);
    do_host(1'b1, 2'd3, 8'h36);

    for (int n = 0; n < 40; n++) begin
      r  = int'($urandom_range(0, 3));
      ra = 2'($urandom_range(0, 3));
      case (r)
        0: do_host(1'b0, ra, 8'($urandom));
        1: begin
          rd0 = 8'($urandom);
          if (ra == 2'd3) rd0[5:4] = 2'b11;
          do_host(1'b1, ra, rd0);
        end
        default: do_snap(ra, 16'($urandom));
      endcase
    end

    // Latch command from the host goes to the bus untouched.
    do_host(1'b1, 2'd3, 8'h40);

    // Reset in the STROBE of a snapshot's first access.
    @(negedge clk);
    sa0 = snap_ack_cnt;
    cnt[1] = 16'($urandom);
    snap_req = 1'b1; snap_ch = 2'd1; t = cyc;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_strobe", {pit_cs, pit_wr, init_done}, 3'b111);
    reset = 1'b1; snap_req = 1'b0;
    @(negedge clk);
    $display("reset during snapshot strobe at t+2=%0d", t + 2);
    chk("abort_strobes_off", {pit_cs, pit_rd, pit_wr}, 0);
    chk("abort_init_done_low", {init_done, snap_ack}, 0);
    clear_log();
    host_ack_cnt = 0; snap_ack_cnt = 0;
    reset = 1'b0;
    check_init("reinit");
    chk("abort_no_snap_ack", snap_ack_cnt, 0);
    chk("abort_no_snap_ack_before", sa0 >= 0 ? 1 : 0, 1);

    // Both requesters held: host first after reset, then strict alternation.
    rd0 = 8'($urandom); cnt0 = 16'($urandom);
    rd_reg[0] = rd0; cnt[0] = cnt0;
    host_req = 1'b1; host_we = 1'b0; host_a = 2'd0;
    snap_req = 1'b1; snap_ch = 2'd0;
    for (int g = 0; g < 4; g++) begin
      c = -1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (host_ack || snap_ack) begin c = cyc; break; end
      end
      $display("grant %0d: host_ack=%0d snap_ack=%0d cycle=%0d", g, host_ack, snap_ack, c);
      chk($sformatf("rr_order%0d", g), {host_ack, snap_ack}, (g % 2 == 0) ? 2'b10 : 2'b01);
      if (host_ack) chk("rr_host_rdata", host_rdata, rd0);
      if (snap_ack) chk("rr_snap_val", snap_val, cnt0);
    end
    host_req = 1'b0; snap_req = 1'b0;
    repeat (3) @(negedge clk);

    chk("protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
